pipeline_exec_controller: RTL
=============================

# pipeline_exec_controller

Sequencing controller for the five-stage MIPS pipeline. It decides every cycle whether the pipeline advances, stalls on a load-use hazard, or flushes IF/ID on a taken branch. It provides run, single-step and halt control for the debug unit. It sits beside the EX forwarding logic and the ID hazard path, and drives the PC, IF/ID, ID/EX and EX/M/WB register enables.

## Interface
Parameters:
- NB_REG, 5, register identifier width
- NB_CNT, 32, width of the cycle and stall counters

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_run_cmd  input  1  one-cycle pulse: enter continuous run
- i_step_cmd  input  1  one-cycle pulse: advance exactly one cycle
- i_halt_cmd  input  1  one-cycle pulse: stop continuous run
- i_halt_instr_WB  input  1  HALT instruction is in WB this cycle
- i_MemRead_from_EX  input  1  instruction in EX is a load
- i_rt_from_EX  input  NB_REG  load destination in EX
- i_rs_from_ID  input  NB_REG  rs of instruction in ID
- i_rt_from_ID  input  NB_REG  rt of instruction in ID
- i_branch_taken_ID  input  1  branch/jump resolved taken in ID
- o_pc_en  output  1  PC write enable
- o_ifid_en  output  1  IF/ID write enable
- o_ifid_flush  output  1  IF/ID load NOP
- o_idex_bubble  output  1  ID/EX load control-zero bubble
- o_pipe_en  output  1  global enable, ID/EX through M/WB
- o_state  output  2  current FSM state
- o_cycle_count  output  NB_CNT  advanced cycles since reset
- o_stall_count  output  NB_CNT  load-use stall cycles since reset
- o_done  output  1  one-cycle pulse at step completion or halt

## Operation
- FSM states (2'b): IDLE=00, RUN=01, STEP=10, HALTED=11. Reset state is IDLE.
- Transitions:
  - IDLE: run_cmd → RUN. Else step_cmd → STEP. If run_cmd and step_cmd arrive together, RUN wins. halt_cmd is ignored.
  - RUN: halt_instr_WB → HALTED, taking priority over a simultaneous halt_cmd. Else halt_cmd → IDLE. run_cmd and step_cmd are ignored.
  - STEP: unconditionally leaves after one cycle. Goes to HALTED if halt_instr_WB, else IDLE. All commands are ignored.
  - HALTED: sticky. All commands are ignored. Only i_rst exits.
- adv = (state==RUN) | (state==STEP).
- load_use = i_MemRead_from_EX & (i_rt_from_EX!=0) & ((i_rt_from_EX==i_rs_from_ID) | (i_rt_from_EX==i_rt_from_ID)).
- Combinational outputs:
  - o_pipe_en = adv.
  - o_pc_en = o_ifid_en = adv & ~load_use.
  - o_idex_bubble = adv & load_use.
  - o_ifid_flush = adv & ~load_use & i_branch_taken_ID. Load-use has priority and the branch re-resolves next cycle.
- Outside RUN/STEP, all enables, flush and bubble are 0, and hazard inputs are don't-care.
- o_cycle_count increments on every edge where adv=1. It saturates at all-ones and does not wrap.
- o_stall_count increments on every edge where adv & load_use. It saturates at all-ones.
- o_done is registered:
  - High for exactly one cycle after any edge that leaves STEP.
  - High for exactly one cycle after any edge that enters HALTED from RUN.
- o_state is the registered state.

## Timing
- Commands are sampled on the rising edge. A pulse at edge k changes state at k. Enables reflect the new state during cycle k+1, until edge k+2.
- A step yields exactly one adv cycle. A stall during a step counts as that step: the bubble is inserted and the PC holds.
- HALT is seen in WB during an adv cycle. That edge commits HALT's writeback and enters HALTED. Zero further advancing cycles follow.
- Reset values: state IDLE, all enables/flush/bubble 0, both counters 0, o_done 0.
- Reset asserted mid-RUN forces IDLE asynchronously. Enables drop immediately (combinational from state).
- Latency of load_use, flush and enables from their inputs is zero cycles (combinational).

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - The state encodings STATE_IDLE/RUN/STEP/HALTED.
  - The counter width default.
- Sub-module load_use_detector: purely combinational, parameter NB_REG. Inputs are the MemRead and rt from EX and rs/rt from ID. Output is load_use.
- FSM, counters and o_done register stay in the top.

## Test plan
- Reset, then step_cmd pulse with no hazard → o_pipe_en=o_pc_en=1 for exactly 1 cycle, o_done pulse the cycle after, o_cycle_count=1, state back to IDLE.
- RUN with MemRead_EX=1, rt_EX=5, rs_ID=5, branch_taken=1 → pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0, stall_count+1. Repeat with rt_EX=0 → no stall, ifid_flush=1.
- RUN for 10 cycles, then halt_instr_WB=1 together with halt_cmd → state HALTED, cycle_count=10 (including the HALT cycle), o_done one pulse. Subsequent run_cmd and step_cmd are ignored.
- IDLE with run_cmd and step_cmd in the same cycle → RUN. Later halt_cmd → IDLE, enables 0 the next cycle, cycle_count frozen.
- NB_CNT=4, run 20 cycles → o_cycle_count saturates at 15.
- Async i_rst pulse mid-RUN, between clock edges → outputs go to reset values before the next edge, state IDLE, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline execution controller.
//   state_e        : FSM state encoding, also driven out on o_state
//   NB_CNT_DEFAULT : default width of the cycle and stall counters
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'b00,
    STATE_RUN    = 2'b01,
    STATE_STEP   = 2'b10,
    STATE_HALTED = 2'b11
  } state_e;

  localparam int NB_CNT_DEFAULT = 32;

endpackage

// File: rtl/pipeline_exec_controller_load_use_detector.sv
// Load-use hazard detector. This block is purely combinational.
// It flags a hazard when the load in EX writes a nonzero register
// that the instruction in ID reads as rs or rt.
//   i_mem_read_ex : EX instruction is a load
//   i_rt_ex       : load destination register
//   i_rs_id       : rs of the ID instruction
//   i_rt_id       : rt of the ID instruction
//   o_load_use    : hazard, so stall IF/ID and bubble ID/EX
module load_use_detector #(
  parameter int NB_REG = 5
) (
  input  logic              i_mem_read_ex,
  input  logic [NB_REG-1:0] i_rt_ex,
  input  logic [NB_REG-1:0] i_rs_id,
  input  logic [NB_REG-1:0] i_rt_id,
  output logic              o_load_use
);

  // $zero is never a real dependency.
  assign o_load_use = i_mem_read_ex & (i_rt_ex != '0) &
                      ((i_rt_ex == i_rs_id) | (i_rt_ex == i_rt_id));

endmodule

// File: rtl/pipeline_exec_controller.sv
// Sequencing controller for the five-stage pipeline. It covers three jobs:
//   - run/step/halt control for the debug unit
//   - load-use stall
//   - IF/ID flush on a taken branch
// Ports:
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_run_cmd/step/halt    : one-cycle debug command pulses
//   i_halt_instr_WB        : HALT instruction in WB
//   i_MemRead_from_EX, i_rt_from_EX, i_rs_from_ID, i_rt_from_ID : hazard inputs
//   i_branch_taken_ID      : taken branch/jump resolved in ID
//   o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_en : pipeline controls
//   o_state                : registered FSM state
//   o_cycle_count, o_stall_count : saturating counters
//   o_done                 : pulse after a step completes or HALT is reached
//
// state  | meaning
// IDLE   | pipeline frozen, waiting for run/step command
// RUN    | advancing every cycle until halt_cmd or HALT in WB
// STEP   | single advancing cycle, then back to IDLE (or HALTED)
// HALTED | HALT retired; frozen until reset
module pipeline_exec_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG = 5,
  parameter int NB_CNT = NB_CNT_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run_cmd,
  input  logic              i_step_cmd,
  input  logic              i_halt_cmd,
  input  logic              i_halt_instr_WB,
  input  logic              i_MemRead_from_EX,
  input  logic [NB_REG-1:0] i_rt_from_EX,
  input  logic [NB_REG-1:0] i_rs_from_ID,
  input  logic [NB_REG-1:0] i_rt_from_ID,
  input  logic              i_branch_taken_ID,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_pipe_en,
  output logic [1:0]        o_state,
  output logic [NB_CNT-1:0] o_cycle_count,
  output logic [NB_CNT-1:0] o_stall_count,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic [NB_CNT-1:0] cycle_q, cycle_d;
  logic [NB_CNT-1:0] stall_q, stall_d;
  logic              done_q, done_d;
  logic              load_use;
  logic              adv;

  load_use_detector #(.NB_REG(NB_REG)) u_load_use_detector (
    .i_mem_read_ex (i_MemRead_from_EX),
    .i_rt_ex       (i_rt_from_EX),
    .i_rs_id       (i_rs_from_ID),
    .i_rt_id       (i_rt_from_ID),
    .o_load_use    (load_use)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= STATE_IDLE;
      cycle_q <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (i_run_cmd)       state_d = STATE_RUN;
        else if (i_step_cmd) state_d = STATE_STEP;
      end
      STATE_RUN: begin
        // A HALT retiring wins over a debugger halt in the same cycle.
        if (i_halt_instr_WB) begin
          state_d = STATE_HALTED;
          done_d  = 1'b1;
        end else if (i_halt_cmd) begin
          state_d = STATE_IDLE;
        end
      end
      STATE_STEP: begin
        state_d = i_halt_instr_WB ? STATE_HALTED : STATE_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = STATE_HALTED;
    endcase
  end

  assign adv = (state_q == STATE_RUN) | (state_q == STATE_STEP);

  // Both counters saturate rather than wrap.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (adv && (cycle_q != '1))
      cycle_d = cycle_q + NB_CNT'(1);
    if (adv && load_use && (stall_q != '1))
      stall_d = stall_q + NB_CNT'(1);
  end

  // A stall takes priority over a flush. The branch re-resolves after the bubble.
  assign o_pipe_en     = adv;
  assign o_pc_en       = adv & ~load_use;
  assign o_ifid_en     = adv & ~load_use;
  assign o_idex_bubble = adv & load_use;
  assign o_ifid_flush  = adv & ~load_use & i_branch_taken_ID;

  assign o_state       = state_q;
  assign o_cycle_count = cycle_q;
  assign o_stall_count = stall_q;
  assign o_done        = done_q;

endmodule
